// File: rtl/display_pkg.sv
// display_pkg: mode codes, FSM state encoding and select width shared by the display mode sequencer
package display_pkg;
  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] MODE_RGB     = 3'd1;
  localparam logic [SEL_W-1:0] MODE_GRAY    = 3'd2;
  localparam logic [SEL_W-1:0] MODE_HIST    = 3'd3;
  localparam logic [SEL_W-1:0] MODE_THRESH  = 3'd4;
  localparam logic [SEL_W-1:0] MODE_CUMHIST = 3'd5;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SETTLE  = 2'd2
  } state_t;
endpackage

// File: rtl/frame_edge_det.sv
// frame_edge_det: registers frame valid and flags frame start, frame end and stable blanking
//   clk, rst     : clock, synchronous active-high reset
//   fval         : frame valid from the capture path
//   frame_start  : fval rising edge
//   frame_end    : fval falling edge
//   blank_stable : fval low now and on the previous cycle
module frame_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic fval,
  output logic frame_start,
  output logic frame_end,
  output logic blank_stable
);
  logic fval_d;
  always_ff @(posedge clk)
    if (rst) fval_d <= 1'b0;
    else     fval_d <= fval;
  assign frame_start  = fval & ~fval_d;
  assign frame_end    = ~fval & fval_d;
  assign blank_stable = ~fval & ~fval_d;
endmodule

// File: rtl/display_mode_sequencer.sv
// display_mode_sequencer: turns user/auto mode requests into arbitrator select changes committed only in vertical blanking
//   iClk, iRst            : clock, synchronous active-high reset
//   iFval                 : frame valid from the capture path
//   iNext, iPrev          : single-cycle step requests
//   iDirect_Load          : single-cycle load of iMode_Direct
//   iAuto_En              : level, enables auto-cycling every AUTO_FRAMES frame ends
//   oSelect               : committed mode to the arbitrator
//   oPending              : a request is waiting for blanking
//   oBlank                : settle window, downstream drops writes
//   oFrame_Cnt            : free-running frame start counter
module display_mode_sequencer
  import display_pkg::*;
#(
  parameter int NUM_MODES     = 5,
  parameter int AUTO_FRAMES   = 60,
  parameter int SETTLE_FRAMES = 1,
  parameter int SEL_W         = display_pkg::SEL_W
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iFval,
  input  logic             iNext,
  input  logic             iPrev,
  input  logic             iDirect_Load,
  input  logic [SEL_W-1:0] iMode_Direct,
  input  logic             iAuto_En,
  output logic [SEL_W-1:0] oSelect,
  output logic             oPending,
  output logic             oBlank,
  output logic [15:0]      oFrame_Cnt
);
  logic frame_start, frame_end, blank_stable;
  logic dir_ok, man, auto_tick, req;
  logic [SEL_W-1:0] target, t_next, t_prev, t_req, tgt_n;
  logic [15:0] auto_cnt, settle_cnt;
  state_t state;

  frame_edge_det u_edge (
    .clk         (iClk),
    .rst         (iRst),
    .fval        (iFval),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .blank_stable(blank_stable)
  );

  // Invalid direct codes are dropped, letting lower-priority requests through.
  assign dir_ok    = iDirect_Load && (iMode_Direct != '0) && (int'(iMode_Direct) <= NUM_MODES);
  assign man       = dir_ok | iNext | iPrev;
  assign auto_tick = iAuto_En && frame_end && (auto_cnt == 16'(AUTO_FRAMES - 1));
  assign req       = man | auto_tick;
  assign t_next    = (target == SEL_W'(NUM_MODES)) ? SEL_W'(1) : target + SEL_W'(1);
  assign t_prev    = (target == SEL_W'(1)) ? SEL_W'(NUM_MODES) : target - SEL_W'(1);
  assign t_req     = dir_ok ? iMode_Direct : iNext ? t_next : iPrev ? t_prev : t_next;
  // Commits and settle exits use the post-request target so a same-cycle request is never lost.
  assign tgt_n     = req ? t_req : target;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oSelect    <= SEL_W'(MODE_RGB);
      target     <= SEL_W'(MODE_RGB);
      oPending   <= 1'b0;
      oBlank     <= 1'b0;
      oFrame_Cnt <= '0;
      auto_cnt   <= '0;
      settle_cnt <= '0;
      state      <= IDLE;
    end else begin
      if (frame_start) oFrame_Cnt <= oFrame_Cnt + 16'd1;
      auto_cnt <= (!iAuto_En || man || auto_tick) ? '0 : frame_end ? auto_cnt + 16'd1 : auto_cnt;
      target   <= tgt_n;
      case (state)
        IDLE:
          if (req) begin
            state    <= PENDING;
            oPending <= 1'b1;
          end
        PENDING:
          if (blank_stable) begin
            oSelect  <= tgt_n;
            oPending <= 1'b0;
            if (tgt_n != oSelect && SETTLE_FRAMES != 0) begin
              state      <= SETTLE;
              oBlank     <= 1'b1;
              settle_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end
        SETTLE:
          if (frame_end) begin
            if (settle_cnt == 16'(SETTLE_FRAMES - 1)) begin
              oBlank   <= 1'b0;
              state    <= (tgt_n != oSelect) ? PENDING : IDLE;
              oPending <= tgt_n != oSelect;
            end else begin
              settle_cnt <= settle_cnt + 16'd1;
            end
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
